adc_avg8: RTL and testbench



---
 rtl/adc_avg8.sv | 141 ++++++++++++++
 tb/tb_adc_avg8.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_avg8.sv
// adc_avg8: decimating averager for the eight 12-bit ADC channel words.
// Every TICK_DIV cycles all eight channels are snapshotted on one edge.
// The snapshots are accumulated one channel per cycle through a single adder.
// After 2^LOG2N snapshots the eight truncated averages are published together
// with a one-cycle AVG_VALID strobe.
module adc_avg8 #(
  parameter int TICK_DIV = 50000,
  parameter int LOG2N    = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  output logic [11:0] AVG0,
  output logic [11:0] AVG1,
  output logic [11:0] AVG2,
  output logic [11:0] AVG3,
  output logic [11:0] AVG4,
  output logic [11:0] AVG5,
  output logic [11:0] AVG6,
  output logic [11:0] AVG7,
  output logic        AVG_VALID,
  output logic        BUSY
);

  localparam int ACC_W = 12 + LOG2N;
  localparam int NS_W  = LOG2N + 1;
  localparam logic [15:0]     TICK_LAST  = 16'(TICK_DIV - 1);
  localparam logic [NS_W-1:0] NSAMP_LAST = NS_W'((1 << LOG2N) - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_ACC,
    ST_DUMP
  } state_t;

  state_t           state;
  logic [15:0]      tcnt;
  logic             tick;
  logic [11:0]      ch   [8];
  logic [11:0]      snap [8];
  logic [ACC_W-1:0] acc  [8];
  logic [11:0]      avg  [8];
  logic [2:0]       idx;
  logic [NS_W-1:0]  nsamp;

  assign ch[0] = CH0;
  assign ch[1] = CH1;
  assign ch[2] = CH2;
  assign ch[3] = CH3;
  assign ch[4] = CH4;
  assign ch[5] = CH5;
  assign ch[6] = CH6;
  assign ch[7] = CH7;

  assign AVG0 = avg[0];
  assign AVG1 = avg[1];
  assign AVG2 = avg[2];
  assign AVG3 = avg[3];
  assign AVG4 = avg[4];
  assign AVG5 = avg[5];
  assign AVG6 = avg[6];
  assign AVG7 = avg[7];

  assign tick = (tcnt == TICK_LAST);

  // Free-running sample-rate counter; it never stalls, whatever the FSM is doing.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 16'd1;
    end
  end

  // Snapshot / accumulate / publish sequencer, with AVG, AVG_VALID and BUSY registered.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= ST_WAIT;
      idx       <= '0;
      nsamp     <= '0;
      AVG_VALID <= 1'b0;
      BUSY      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        snap[i] <= '0;
        acc[i]  <= '0;
        avg[i]  <= '0;
      end
    end else begin
      AVG_VALID <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (tick) begin
            for (int i = 0; i < 8; i++) begin
              snap[i] <= ch[i];
            end
            idx   <= '0;
            state <= ST_ACC;
            BUSY  <= 1'b1;
          end
        end
        ST_ACC: begin
          acc[idx] <= acc[idx] + ACC_W'(snap[idx]);
          idx      <= idx + 3'd1;
          if (idx == 3'd7) begin
            nsamp <= nsamp + NS_W'(1);
            if (nsamp == NSAMP_LAST) begin
              state <= ST_DUMP;
            end else begin
              state <= ST_WAIT;
              BUSY  <= 1'b0;
            end
          end
        end
        ST_DUMP: begin
          for (int i = 0; i < 8; i++) begin
            avg[i] <= 12'(acc[i] >> LOG2N);
            acc[i] <= '0;
          end
          AVG_VALID <= 1'b1;
          nsamp     <= '0;
          state     <= ST_WAIT;
          BUSY      <= 1'b0;
        end
        default: begin
          state <= ST_WAIT;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_avg8.sv
// tb_adc_avg8: three adc_avg8 instances with different parameter sets, each
// compared cycle by cycle against a behavioural model, plus hand-computed
// expectations for latency, pulse spacing and averaged values.
module tb_adc_avg8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst     [3];
  logic [11:0] ch_i    [3][8];
  logic [11:0] avg_o   [3][8];
  logic        valid_o [3];
  logic        busy_o  [3];

  int n_pass  = 0;
  int n_total = 0;
  bit toggle_en = 1'b0;

  // Model state: sample-rate phase, cycles of busy left, running sums per channel.
  int m_tc   [3];
  int m_left [3];
  int m_n    [3];
  int m_sum  [3][8];
  int m_pend [3][8];
  int m_avg  [3][8];
  bit m_valid[3];
  bit m_dump [3];

  // Instance 0: TICK_DIV=16, LOG2N=2 (main directed tests).
  adc_avg8 #(.TICK_DIV(16), .LOG2N(2)) dut_a (
    .CLOCK(clock), .RESET(rst[0]),
    .CH0(ch_i[0][0]), .CH1(ch_i[0][1]), .CH2(ch_i[0][2]), .CH3(ch_i[0][3]),
    .CH4(ch_i[0][4]), .CH5(ch_i[0][5]), .CH6(ch_i[0][6]), .CH7(ch_i[0][7]),
    .AVG0(avg_o[0][0]), .AVG1(avg_o[0][1]), .AVG2(avg_o[0][2]), .AVG3(avg_o[0][3]),
    .AVG4(avg_o[0][4]), .AVG5(avg_o[0][5]), .AVG6(avg_o[0][6]), .AVG7(avg_o[0][7]),
    .AVG_VALID(valid_o[0]), .BUSY(busy_o[0])
  );

  // Instance 1: saturation, 256 samples per average.
  adc_avg8 #(.TICK_DIV(12), .LOG2N(8)) dut_b (
    .CLOCK(clock), .RESET(rst[1]),
    .CH0(ch_i[1][0]), .CH1(ch_i[1][1]), .CH2(ch_i[1][2]), .CH3(ch_i[1][3]),
    .CH4(ch_i[1][4]), .CH5(ch_i[1][5]), .CH6(ch_i[1][6]), .CH7(ch_i[1][7]),
    .AVG0(avg_o[1][0]), .AVG1(avg_o[1][1]), .AVG2(avg_o[1][2]), .AVG3(avg_o[1][3]),
    .AVG4(avg_o[1][4]), .AVG5(avg_o[1][5]), .AVG6(avg_o[1][6]), .AVG7(avg_o[1][7]),
    .AVG_VALID(valid_o[1]), .BUSY(busy_o[1])
  );

  // Instance 2: shortest period, no averaging.
  adc_avg8 #(.TICK_DIV(12), .LOG2N(0)) dut_c (
    .CLOCK(clock), .RESET(rst[2]),
    .CH0(ch_i[2][0]), .CH1(ch_i[2][1]), .CH2(ch_i[2][2]), .CH3(ch_i[2][3]),
    .CH4(ch_i[2][4]), .CH5(ch_i[2][5]), .CH6(ch_i[2][6]), .CH7(ch_i[2][7]),
    .AVG0(avg_o[2][0]), .AVG1(avg_o[2][1]), .AVG2(avg_o[2][2]), .AVG3(avg_o[2][3]),
    .AVG4(avg_o[2][4]), .AVG5(avg_o[2][5]), .AVG6(avg_o[2][6]), .AVG7(avg_o[2][7]),
    .AVG_VALID(valid_o[2]), .BUSY(busy_o[2])
  );

  // A snapshot adds the whole sample to the sums at once; the averager is then
  // busy for 8 cycles, or 9 when that sample completes a block, and the
  // average appears when the 9-cycle busy period ends.
  task automatic model_step(input int k, input int td, input int l2n);
    bit tick;
    if (rst[k]) begin
      m_tc[k] = 0; m_left[k] = 0; m_n[k] = 0;
      m_valid[k] = 1'b0; m_dump[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_sum[k][i] = 0; m_pend[k][i] = 0; m_avg[k][i] = 0;
      end
    end else begin
      m_valid[k] = 1'b0;
      tick = (m_tc[k] == td - 1);
      m_tc[k] = (m_tc[k] + 1) % td;
      if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0 && m_dump[k]) begin
          for (int i = 0; i < 8; i++) m_avg[k][i] = m_pend[k][i];
          m_valid[k] = 1'b1;
          m_dump[k]  = 1'b0;
        end
      end else if (tick) begin
        for (int i = 0; i < 8; i++) m_sum[k][i] += int'(ch_i[k][i]);
        m_n[k]++;
        if (m_n[k] == (1 << l2n)) begin
          for (int i = 0; i < 8; i++) begin
            m_pend[k][i] = m_sum[k][i] / (1 << l2n);
            m_sum[k][i]  = 0;
          end
          m_n[k]    = 0;
          m_dump[k] = 1'b1;
          m_left[k] = 9;
        end else begin
          m_left[k] = 8;
        end
      end
    end
  endtask

  // Advance all three models on the same edge the DUTs see.
  always @(posedge clock) begin
    model_step(0, 16, 2);
    model_step(1, 12, 8);
    model_step(2, 12, 0);
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++)
        check_output($sformatf("dut%0d AVG%0d", k, i), int'(avg_o[k][i]), m_avg[k][i]);
      check_output($sformatf("dut%0d AVG_VALID", k), int'(valid_o[k]), int'(m_valid[k]));
      check_output($sformatf("dut%0d BUSY", k), int'(busy_o[k]), int'(m_left[k] > 0));
    end
  endtask

  // One cycle: sample on the falling edge, compare, then drive the next inputs.
  task automatic next_cycle();
    @(negedge clock);
    compare_all();
    if (toggle_en) ch_i[0][3] = (m_tc[0] % 2 == 1) ? 12'd4095 : 12'd0;
  endtask

  task automatic next_n(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic apply_stimulus(input int k, input int base, input int stride);
    for (int i = 0; i < 8; i++) ch_i[k][i] = 12'(base + stride * i);
  endtask

  task automatic wait_valid(input int k, input int limit, output int cycles);
    cycles = 0;
    do begin
      next_cycle();
      cycles++;
    end while (!valid_o[k] && cycles < limit);
    if (!valid_o[k]) check_output($sformatf("dut%0d valid timeout", k), 0, 1);
  endtask

  task automatic pulse_reset(input int k);
    rst[k] = 1'b1;
    next_cycle();
    rst[k] = 1'b0;
  endtask

  // Directed sequence; every cycle also goes through the model comparison.
  initial begin
    int cyc;
    int nv;
    int nb;
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    apply_stimulus(0, 100, 100);
    apply_stimulus(1, 4095, 0);
    apply_stimulus(2, 37, 500);
    next_n(2);

    for (int i = 0; i < 8; i++) check_output($sformatf("reset AVG%0d", i), int'(avg_o[0][i]), 0);
    check_output("reset AVG_VALID", int'(valid_o[0]), 0);
    check_output("reset BUSY", int'(busy_o[0]), 0);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Constant input: first tick at edge 16, fourth at 64, published at 73.
    wait_valid(0, 500, cyc);
    check_output("const first latency", cyc, 73);
    for (int i = 0; i < 8; i++) check_output($sformatf("const AVG%0d", i), int'(avg_o[0][i]), 100 * (i + 1));
    wait_valid(0, 500, cyc);
    check_output("const pulse spacing", cyc, 64);

    // Reset with idx=4 of the third sample (tick 176, four edges on).
    next_n(43);
    rst[0] = 1'b1;
    apply_stimulus(0, 50, 0);
    next_cycle();
    for (int i = 0; i < 8; i++) check_output($sformatf("midreset AVG%0d", i), int'(avg_o[0][i]), 0);
    check_output("midreset AVG_VALID", int'(valid_o[0]), 0);
    check_output("midreset BUSY", int'(busy_o[0]), 0);
    rst[0] = 1'b0;
    wait_valid(0, 500, cyc);
    check_output("midreset latency", cyc, 73);
    for (int i = 0; i < 8; i++) check_output($sformatf("midreset AVG%0d=50", i), int'(avg_o[0][i]), 50);

    // Truncation: CH0 = 1,2,2,2 -> 7/4 = 1; CH2 = 3,4,4,4 -> 15/4 = 3.
    rst[0] = 1'b1;
    apply_stimulus(0, 0, 0);
    ch_i[0][0] = 12'd1;
    ch_i[0][2] = 12'd3;
    next_cycle();
    rst[0] = 1'b0;
    next_n(16);
    ch_i[0][0] = 12'd2;
    ch_i[0][2] = 12'd4;
    wait_valid(0, 500, cyc);
    check_output("trunc AVG0", int'(avg_o[0][0]), 1);
    check_output("trunc AVG2", int'(avg_o[0][2]), 3);

    // Coherence: CH3 toggles every cycle but is 4095 on every snapshot edge.
    rst[0] = 1'b1;
    apply_stimulus(0, 0, 0);
    next_cycle();
    rst[0] = 1'b0;
    toggle_en = 1'b1;
    wait_valid(0, 500, cyc);
    toggle_en = 1'b0;
    check_output("coherence AVG3", int'(avg_o[0][3]), 4095);
    check_output("coherence AVG0", int'(avg_o[0][0]), 0);

    // Period check: LOG2N=0, TICK_DIV=12.
    wait_valid(2, 50, cyc);
    nv = 0;
    nb = 0;
    for (int c = 0; c < 48; c++) begin
      next_cycle();
      if (valid_o[2]) nv++;
      if (busy_o[2]) nb++;
    end
    check_output("period valid count", nv, 4);
    check_output("period busy cycles", nb, 36);
    wait_valid(2, 50, cyc);
    check_output("period spacing", cyc, 12);
    check_output("period AVG0", int'(avg_o[2][0]), 37);
    check_output("period AVG7", int'(avg_o[2][7]), 3537);

    // Saturation: 256 samples of 4095 must average to 4095 with no wrap.
    wait_valid(1, 7000, cyc);
    for (int i = 0; i < 8; i++) check_output($sformatf("sat AVG%0d", i), int'(avg_o[1][i]), 4095);
    wait_valid(1, 4000, cyc);
    check_output("sat pulse spacing", cyc, 3072);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
